// File: rtl/cpu_run_monitor_if.sv
// CPU retirement sample and trace read port shared by the run monitor and its host.
interface cpu_run_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              reg_write;
  logic [REG_W-1:0]  wreg;
  logic [DATA_W-1:0] wdata;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_wreg;
  logic [DATA_W-1:0] rd_wdata;

  modport master (
    output pc, reg_write, wreg, wdata, rd_idx,
    input  rd_valid, rd_pc, rd_wreg, rd_wdata
  );

  modport slave (
    input  pc, reg_write, wreg, wdata, rd_idx,
    output rd_valid, rd_pc, rd_wreg, rd_wdata
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle CPU: gates execution, counts cycles,
// stops on cycle limit / halt address / self-loop, and traces register writes.
module cpu_run_monitor #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned CNT_W      = 16,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 32'hFFFF_FFFC,
  parameter int unsigned LOOP_N     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  cpu_run_monitor_if.slave       bus,
  output logic                   cpu_run,
  output logic                   done,
  output logic [1:0]             halt_cause,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       write_count,
  output logic [$clog2(DEPTH):0] trace_count,
  output logic                   trace_overflow
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TC_W  = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cycle_nxt, write_nxt, repeat_cnt, rep_nxt;
  logic [TC_W-1:0]   tcount_nxt;
  logic              ovf_nxt, run_nxt, done_nxt, have_prev, have_prev_nxt;
  logic [1:0]        cause_nxt;
  logic [IDX_W-1:0]  wr_ptr, wptr_nxt, oldest, phys;
  logic [ADDR_W-1:0] prev_pc, prev_pc_nxt;
  logic              mem_we, same_pc, qual, full, halt_hit, loop_hit, limit_hit;
  entry_t            mem [DEPTH];
  entry_t            rd_e;

  // Next-state, counter and trace-pointer logic.
  always_comb begin
    state_nxt     = state;
    cycle_nxt     = cycle_count;
    write_nxt     = write_count;
    tcount_nxt    = trace_count;
    ovf_nxt       = trace_overflow;
    cause_nxt     = halt_cause;
    wptr_nxt      = wr_ptr;
    prev_pc_nxt   = prev_pc;
    rep_nxt       = repeat_cnt;
    have_prev_nxt = have_prev;
    mem_we        = 1'b0;
    full          = (trace_count == TC_W'(DEPTH));
    same_pc       = have_prev && (bus.pc == prev_pc);
    qual          = bus.reg_write && (bus.wreg != '0);
    halt_hit      = (bus.pc == HALT_ADDR);
    loop_hit      = same_pc && ((repeat_cnt + CNT_W'(1)) == CNT_W'(LOOP_N));
    limit_hit     = ((cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES));

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = RUN;
          cycle_nxt     = '0;
          write_nxt     = '0;
          tcount_nxt    = '0;
          ovf_nxt       = 1'b0;
          cause_nxt     = 2'd0;
          wptr_nxt      = '0;
          rep_nxt       = '0;
          have_prev_nxt = 1'b0;
        end
      end
      RUN: begin
        cycle_nxt     = cycle_count + CNT_W'(1);
        prev_pc_nxt   = bus.pc;
        have_prev_nxt = 1'b1;
        rep_nxt       = same_pc ? repeat_cnt + CNT_W'(1) : '0;
        if (qual) begin
          mem_we   = 1'b1;
          wptr_nxt = wr_ptr + IDX_W'(1);
          if (write_count != '1) write_nxt = write_count + CNT_W'(1);
          if (full) ovf_nxt = 1'b1;
          else      tcount_nxt = trace_count + TC_W'(1);
        end
        if (halt_hit) begin
          cause_nxt = 2'd2;
          state_nxt = DONE;
        end else if (loop_hit) begin
          cause_nxt = 2'd3;
          state_nxt = DONE;
        end else if (limit_hit) begin
          cause_nxt = 2'd1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    run_nxt  = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cpu_run        <= 1'b0;
      done           <= 1'b0;
      halt_cause     <= 2'd0;
      cycle_count    <= '0;
      write_count    <= '0;
      trace_count    <= '0;
      trace_overflow <= 1'b0;
      wr_ptr         <= '0;
      prev_pc        <= '0;
      repeat_cnt     <= '0;
      have_prev      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cpu_run        <= run_nxt;
      done           <= done_nxt;
      halt_cause     <= cause_nxt;
      cycle_count    <= cycle_nxt;
      write_count    <= write_nxt;
      trace_count    <= tcount_nxt;
      trace_overflow <= ovf_nxt;
      wr_ptr         <= wptr_nxt;
      prev_pc        <= prev_pc_nxt;
      repeat_cnt     <= rep_nxt;
      have_prev      <= have_prev_nxt;
    end
  end

  // Trace RAM; contents survive restarts, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr] <= '{pc: bus.pc, wreg: bus.wreg, wdata: bus.wdata};
  end

  // Combinational read, indexed from the oldest retained entry.
  always_comb begin
    oldest       = full ? wr_ptr : '0;
    phys         = bus.rd_idx + oldest;
    rd_e         = mem[phys];
    bus.rd_valid = (TC_W'(bus.rd_idx) < trace_count);
    bus.rd_pc    = bus.rd_valid ? rd_e.pc    : '0;
    bus.rd_wreg  = bus.rd_valid ? rd_e.wreg  : '0;
    bus.rd_wdata = bus.rd_valid ? rd_e.wdata : '0;
  end
endmodule
